// File: rtl/score_display_driver.sv
// score_display_driver: scans a 2-digit multiplexed 7-segment display.
// Player 1 is shown on digit 0 and player 2 on digit 1. One blank cycle
// separates the digit slots to suppress ghosting. A player's digit blinks
// for a fixed number of off/on cycles whenever that player's score changes.
module score_display_driver #(
  parameter int unsigned REFRESH_LIMIT = 25000,
  parameter int unsigned BLINK_TICKS   = 250,
  parameter int unsigned BLINK_COUNT   = 3,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] p1_score_i,
  input  logic [3:0] p2_score_i,
  input  logic       enable_i,
  output logic [6:0] seg_o,
  output logic [1:0] dig_o,
  output logic       blink_busy_o
);

  localparam int unsigned CNT_W = $clog2(REFRESH_LIMIT);
  localparam int unsigned TCK_W = $clog2(BLINK_TICKS + 1);
  localparam int unsigned BLK_W = $clog2(BLINK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_LIMIT - 1);
  localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(BLINK_TICKS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OFF  = 2'd1,
    ST_ON   = 2'd2
  } blink_state_e;

  // Active-high segment pattern for a hex digit, bit0 = a ... bit6 = g.
  function automatic logic [6:0] decode_hex(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0] count_q, count_d;
  logic             slot_q, slot_d;
  logic             tick;
  logic [3:0]       score_in [2];
  logic [3:0]       sh_q     [2];
  logic [1:0]       change;

  blink_state_e     state_q  [2];
  logic [TCK_W-1:0] tcnt_q   [2];
  logic [BLK_W-1:0] bcnt_q   [2];

  logic [6:0]       seg_q, seg_d;
  logic [1:0]       dig_q, dig_d;

  assign score_in[0] = p1_score_i;
  assign score_in[1] = p2_score_i;
  assign change[0]   = (p1_score_i != sh_q[0]);
  assign change[1]   = (p2_score_i != sh_q[1]);

  // Refresh counter wrap and slot toggle on each slot tick.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    tick    = (count_q == CNT_LAST);
    count_d = count_q + CNT_W'(1);
    slot_d  = slot_q;
    if (tick) begin
      count_d = '0;
      slot_d  = ~slot_q;
    end
  end

  // Refresh counter, slot select and score shadow registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst_i) begin
      count_q <= '0;
      slot_q  <= 1'b0;
      // NOTE: shadows are reset to zero on purpose: a nonzero score at reset release then counts as a change and blinks.
      sh_q[0] <= '0;
      sh_q[1] <= '0;
    end else begin
      count_q <= count_d;
      slot_q  <= slot_d;
      sh_q[0] <= score_in[0];
      sh_q[1] <= score_in[1];
    end
  end

  // Per-player blink FSM; a score change restarts the sequence and beats a same-cycle expiry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= ST_IDLE;
        tcnt_q[p]  <= '0;
        bcnt_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (change[p]) begin
          state_q[p] <= ST_OFF;
          tcnt_q[p]  <= '0;
          bcnt_q[p]  <= '0;
        end else if (tick) begin
          case (state_q[p])
            ST_OFF: begin
              if (tcnt_q[p] == TCK_LAST) begin
                state_q[p] <= ST_ON;
                tcnt_q[p]  <= '0;
              end else begin
                tcnt_q[p]  <= tcnt_q[p] + TCK_W'(1);
              end
            end
            ST_ON: begin
              if (tcnt_q[p] == TCK_LAST) begin
                tcnt_q[p] <= '0;
                if (bcnt_q[p] == BLK_LAST) begin
                  state_q[p] <= ST_IDLE;
                  bcnt_q[p]  <= '0;
                end else begin
                  state_q[p] <= ST_OFF;
                  bcnt_q[p]  <= bcnt_q[p] + BLK_W'(1);
                end
              end else begin
                tcnt_q[p] <= tcnt_q[p] + TCK_W'(1);
              end
            end
            default: begin
              state_q[p] <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  // Next segment/anode pattern: blank on slot boundary, when dark, or during a blink-off phase.
  always_comb begin
    logic       blank;
    logic [6:0] seg_act;
    logic [1:0] dig_act;
    blank   = tick | ~enable_i | (state_q[slot_q] == ST_OFF);
    seg_act = decode_hex(sh_q[slot_q]);
    dig_act = slot_q ? 2'b10 : 2'b01;
    if (blank) begin
      seg_act = '0;
      dig_act = '0;
    end
    seg_d = seg_act ^ {7{ACTIVE_LOW}};
    dig_d = dig_act ^ {2{ACTIVE_LOW}};
  end

  // Registered display pins, reset to the inactive level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seg_q <= {7{ACTIVE_LOW}};
      dig_q <= {2{ACTIVE_LOW}};
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign seg_o        = seg_q;
  assign dig_o        = dig_q;
  assign blink_busy_o = (state_q[0] != ST_IDLE) | (state_q[1] != ST_IDLE);

endmodule
